// File: rtl/thermo_ctrl_mc.sv
// thermo_ctrl_mc: multi-channel serial temperature sensor reader with per-channel hysteresis heater control
module thermo_ctrl_mc #(
  parameter int NCH = 2,
  parameter int TW = 8,
  parameter int DIV = 4,
  parameter int CONV_CYC = 22000000,
  parameter int HYST = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [TW-1:0]     tpRef,
  input  logic [NCH-1:0]    so,
  output logic              cs,
  output logic              clkS,
  output logic [NCH*TW-1:0] tempReal,
  output logic [NCH-1:0]    onOff,
  output logic [NCH-1:0]    fault,
  output logic              sampleDone
);
  localparam logic [1:0] IDLE = 2'd0, FRAME = 2'd1, DONE = 2'd2, HOLD = 2'd3;
  localparam int CW = $clog2(CONV_CYC + 1);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [TW:0] MAXV = {1'b0, {TW{1'b1}}};
  localparam logic [TW:0] HV = (TW+1)'(HYST);
  logic [1:0] state;
  logic [CW-1:0] intervalCnt;
  logic [PW-1:0] phaseCnt;
  logic [4:0] halfCnt;
  logic [NCH-1:0][15:0] shReg;
  logic lastPhase, frameEnd, idleEnd, unusedDummy;
  logic [TW:0] refW, hSum, lo, hi;
  logic [TW-1:0] tNew [NCH];
  logic [NCH-1:0] onNew;
  assign lastPhase = phaseCnt == PW'(DIV - 1);
  assign frameEnd = lastPhase && halfCnt == 5'd31;
  assign idleEnd = intervalCnt == CW'(CONV_CYC - 1);
  assign unusedDummy = ^shReg;
  assign refW = {1'b0, tpRef};
  assign hSum = refW + HV;
  assign lo = refW >= HV ? refW - HV : '0;
  assign hi = hSum > MAXV ? MAXV : hSum;
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      tNew[i] = {1'b0, shReg[i][14:5]} > 11'(MAXV) ? MAXV[TW-1:0] : shReg[i][5 +: TW];
      onNew[i] = shReg[i][2] ? 1'b0 :
                 lo == hi ? tNew[i] < tpRef :
                 {1'b0, tNew[i]} <= lo ? 1'b1 :
                 {1'b0, tNew[i]} >= hi ? 1'b0 : onOff[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      intervalCnt <= '0;
      phaseCnt <= '0;
      halfCnt <= '0;
      shReg <= '0;
      cs <= 1'b1;
      clkS <= 1'b0;
      tempReal <= '0;
      onOff <= '0;
      fault <= '0;
      sampleDone <= 1'b0;
    end else begin
      sampleDone <= 1'b0;
      case (state)
        IDLE: begin
          intervalCnt <= idleEnd ? '0 : intervalCnt + 1'b1;
          if (idleEnd) begin
            state <= en ? FRAME : HOLD;
            cs <= !en;
          end
        end
        HOLD: if (en) begin
          state <= FRAME;
          cs <= 1'b0;
        end
        FRAME: begin
          // phase and half-period counters wrap to zero exactly at frame end
          phaseCnt <= lastPhase ? '0 : phaseCnt + 1'b1;
          if (lastPhase) begin
            halfCnt <= halfCnt + 1'b1;
            clkS <= !clkS;
            if (!clkS)
              for (int i = 0; i < NCH; i++) shReg[i] <= {shReg[i][14:0], so[i]};
          end
          if (frameEnd) begin
            state <= DONE;
            cs <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          sampleDone <= 1'b1;
          onOff <= onNew;
          for (int i = 0; i < NCH; i++) begin
            fault[i] <= shReg[i][2];
            if (!shReg[i][2]) tempReal[i*TW +: TW] <= tNew[i];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_thermo_ctrl_mc.sv
// tb_thermo_ctrl_mc: directed self-checking bench for thermo_ctrl_mc with a serial sensor model per channel
module tb_thermo_ctrl_mc;
  localparam int NCH = 2, TW = 8, DIV = 2, CONV = 10, HYST = 2;
  logic clk = 0, rst_n = 0, en = 0;
  logic [TW-1:0] tpRef = '0;
  logic [NCH-1:0] so = '0;
  logic cs, clkS, sampleDone;
  logic [NCH*TW-1:0] tempReal;
  logic [NCH-1:0] onOff, fault;
  logic [15:0] chWord [NCH];
  int checks = 0, errors = 0;
  int bitIdx = 0;
  logic prevS = 0;

  thermo_ctrl_mc #(.NCH(NCH), .TW(TW), .DIV(DIV), .CONV_CYC(CONV), .HYST(HYST)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tpRef(tpRef), .so(so), .cs(cs), .clkS(clkS),
    .tempReal(tempReal), .onOff(onOff), .fault(fault), .sampleDone(sampleDone)
  );

  always #5 clk = ~clk;

  // sensor presents the next bit after each clkS rise, MSB first from cs fall
  always @(negedge clk) begin
    if (cs !== 1'b0) bitIdx = 0;
    else if (clkS && !prevS) bitIdx++;
    prevS = clkS;
    for (int i = 0; i < NCH; i++) so[i] = bitIdx < 16 ? chWord[i][15 - bitIdx] : 1'b0;
  end

  task automatic runFrame(output int lowCnt, output int rises, output bit ok);
    int n;
    bit prev;
    n = 0; lowCnt = 0; rises = 0; prev = 0;
    while (cs !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    while (cs === 1'b0 && n < 400) begin
      lowCnt++;
      if (clkS && !prev) rises++;
      prev = clkS;
      @(negedge clk); n++;
    end
    while (sampleDone !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    ok = sampleDone === 1'b1;
  endtask

  task automatic test_reset();
    en = 1; tpRef = 60; chWord[0] = 16'h0C80; chWord[1] = 16'h0640; rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cs, clkS, tempReal, onOff, fault, sampleDone} !== {1'b1, 1'b0, 16'h0, 2'b00, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: cs=%b clkS=%b tempReal=%h onOff=%b fault=%b sampleDone=%b, expected 1 0 0000 00 00 0",
               cs, clkS, tempReal, onOff, fault, sampleDone);
    end
    rst_n = 1;
    repeat (CONV - 1) @(negedge clk);
    checks++;
    if (cs !== 1'b1) begin errors++; $display("FAIL cs_before_conv: cs=%b expected 1", cs); end
    @(negedge clk);
    checks++;
    if (cs !== 1'b0) begin errors++; $display("FAIL cs_fall_at_conv: cs=%b expected 0", cs); end
  endtask

  task automatic test_basic();
    int lowCnt, rises;
    bit ok;
    runFrame(lowCnt, rises, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done: sampleDone never seen"); end
    checks++;
    if (lowCnt != 64) begin errors++; $display("FAIL basic_cs_low: %0d cycles, expected 64", lowCnt); end
    checks++;
    if (rises != 16) begin errors++; $display("FAIL basic_clks_rises: %0d, expected 16", rises); end
    checks++;
    if (tempReal !== 16'h3264) begin errors++; $display("FAIL basic_temp: %h expected 3264", tempReal); end
    checks++;
    if (onOff !== 2'b10 || fault !== 2'b00) begin
      errors++; $display("FAIL basic_onoff_fault: onOff=%b fault=%b expected 10 00", onOff, fault);
    end
    @(negedge clk);
    checks++;
    if (sampleDone !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: sampleDone=%b expected 0", sampleDone); end
  endtask

  task automatic test_hysteresis();
    int vals [5] = '{59, 58, 61, 62, 61};
    bit exps [5] = '{0, 1, 1, 0, 0};
    int lowCnt, rises;
    bit ok;
    tpRef = 60;
    for (int k = 0; k < 5; k++) begin
      chWord[0] = 16'(vals[k] << 5);
      runFrame(lowCnt, rises, ok);
      checks++;
      if (!ok || onOff[0] !== exps[k] || tempReal[7:0] !== 8'(vals[k])) begin
        errors++;
        $display("FAIL hyst_%0d: done=%b onOff0=%b temp0=%0d expected done=1 onOff0=%b temp0=%0d",
                 vals[k], ok, onOff[0], tempReal[7:0], exps[k], vals[k]);
      end
    end
  endtask

  task automatic test_open_sensor();
    int lowCnt, rises;
    bit ok;
    tpRef = 60; chWord[0] = 16'h0C80; chWord[1] = 16'h0640;
    runFrame(lowCnt, rises, ok);
    checks++;
    if (!ok || fault !== 2'b00 || onOff !== 2'b10) begin
      errors++; $display("FAIL open_pre: done=%b fault=%b onOff=%b expected 1 00 10", ok, fault, onOff);
    end
    chWord[1] = 16'h0004;
    runFrame(lowCnt, rises, ok);
    checks++;
    if (!ok || fault !== 2'b10 || onOff !== 2'b00 || tempReal !== 16'h3264) begin
      errors++;
      $display("FAIL open_flag: done=%b fault=%b onOff=%b tempReal=%h expected 1 10 00 3264", ok, fault, onOff, tempReal);
    end
    chWord[1] = 16'h0640;
    runFrame(lowCnt, rises, ok);
    checks++;
    if (!ok || fault !== 2'b00 || onOff !== 2'b10) begin
      errors++; $display("FAIL open_recover: done=%b fault=%b onOff=%b expected 1 00 10", ok, fault, onOff);
    end
  endtask

  task automatic test_saturation();
    int lowCnt, rises;
    bit ok;
    tpRef = 255; chWord[0] = 16'h0C80;
    runFrame(lowCnt, rises, ok);
    checks++;
    if (!ok || onOff !== 2'b11) begin errors++; $display("FAIL sat_pre: done=%b onOff=%b expected 1 11", ok, onOff); end
    chWord[0] = 16'h7FF8;
    runFrame(lowCnt, rises, ok);
    checks++;
    if (!ok || tempReal[7:0] !== 8'd255 || onOff !== 2'b10 || fault !== 2'b00) begin
      errors++;
      $display("FAIL sat_1023: done=%b temp0=%0d onOff=%b fault=%b expected 1 255 10 00", ok, tempReal[7:0], onOff, fault);
    end
    chWord[0] = 16'h2000;
    runFrame(lowCnt, rises, ok);
    checks++;
    if (!ok || tempReal[7:0] !== 8'd255 || onOff[0] !== 1'b0) begin
      errors++; $display("FAIL sat_256: done=%b temp0=%0d onOff0=%b expected 1 255 0", ok, tempReal[7:0], onOff[0]);
    end
  endtask

  task automatic test_en_drop();
    int n;
    bit stayedHigh;
    tpRef = 60; chWord[0] = 16'h0C80; chWord[1] = 16'h0640; en = 1;
    n = 0;
    while (cs !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    en = 0;
    n = 0;
    while (sampleDone !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (sampleDone !== 1'b1 || tempReal !== 16'h3264) begin
      errors++; $display("FAIL en_drop_done: sampleDone=%b tempReal=%h expected 1 3264", sampleDone, tempReal);
    end
    stayedHigh = 1;
    repeat (40) begin @(negedge clk); if (cs !== 1'b1) stayedHigh = 0; end
    checks++;
    if (!stayedHigh) begin errors++; $display("FAIL en_hold_cs: cs went low, expected 1 while en=0"); end
    en = 1;
    @(negedge clk);
    checks++;
    if (cs !== 1'b0) begin errors++; $display("FAIL en_resume: cs=%b expected 0 one cycle after en", cs); end
    n = 0;
    while (sampleDone !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (sampleDone !== 1'b1) begin errors++; $display("FAIL en_resume_done: sampleDone never seen"); end
  endtask

  task automatic test_reset_mid();
    int n, rises, lowCnt;
    bit prev, quiet, ok;
    n = 0; rises = 0; prev = 0;
    while (cs !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    while (rises < 8 && n < 200) begin
      if (clkS && !prev) rises++;
      prev = clkS;
      if (rises < 8) begin @(negedge clk); n++; end
    end
    rst_n = 0;
    #1;
    checks++;
    if ({cs, clkS, tempReal, onOff, fault, sampleDone} !== {1'b1, 1'b0, 16'h0, 2'b00, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: rises=%0d cs=%b clkS=%b tempReal=%h onOff=%b fault=%b sampleDone=%b, expected 1 0 0000 00 00 0",
               rises, cs, clkS, tempReal, onOff, fault, sampleDone);
    end
    @(negedge clk);
    rst_n = 1;
    quiet = 1;
    repeat (CONV - 1) begin @(negedge clk); if (cs !== 1'b1 || sampleDone !== 1'b0) quiet = 0; end
    checks++;
    if (!quiet) begin errors++; $display("FAIL reset_mid_quiet: cs low or sampleDone before interval elapsed"); end
    @(negedge clk);
    checks++;
    if (cs !== 1'b0) begin errors++; $display("FAIL reset_mid_cs_fall: cs=%b expected 0", cs); end
    runFrame(lowCnt, rises, ok);
    checks++;
    if (!ok || tempReal !== 16'h3264 || lowCnt != 64) begin
      errors++; $display("FAIL reset_mid_next: done=%b tempReal=%h low=%0d expected 1 3264 64", ok, tempReal, lowCnt);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_hysteresis();
    test_open_sensor();
    test_saturation();
    test_en_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
